// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    ZERO = 2'd3
  } div_state_e;

  localparam int WIDTH_DEFAULT = 32;
  localparam int DIV_LATENCY   = 34;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dq_next
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The shifted remainder can exceed WIDTH bits when the divisor magnitude is above 2^(WIDTH-1).
  always_comb begin
    shifted  = {rem, dq[WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    dq_next  = {dq[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/divider_seq.sv
// Multicycle signed divider for the HI/LO path: remainder on hi, quotient on lo.
module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loadab,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             busy,
  output logic             divzero
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, dq_q, dq_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] step_rem, step_dq;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dq       (dq_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .dq_next  (step_dq)
  );

  // A same-cycle loadab lets start use the port values directly.
  assign op_a = loadab ? a : a_q;
  assign op_b = loadab ? b : b_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (loadab) begin
          a_d = a;
          b_d = b;
        end
        if (start) begin
          if (op_b == '0) begin
            state_d = ZERO;
          end else begin
            state_d = CALC;
            neg_a_d = op_a[WIDTH-1];
            neg_b_d = op_b[WIDTH-1];
            dq_d    = op_a[WIDTH-1] ? -op_a : op_a;
            dvs_d   = op_b[WIDTH-1] ? -op_b : op_b;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = SIGN;
      end
      SIGN: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        lo_d    = (neg_a_q ^ neg_b_q) ? -dq_q : dq_q;
        hi_d    = neg_a_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      done_q  <= done_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign done    = done_q;
  assign busy    = (state_q == CALC) || (state_q == SIGN);
  assign divzero = (state_q == ZERO);

endmodule
